// File: rtl/dlsc_pcie_s6_outbound_read_pkg.sv
// Shared definitions for the outbound read completion-buffer allocator.
package dlsc_pcie_s6_outbound_read_pkg;

    // Allocator sequencing: one command moves INIT->IDLE->CHECK->ALLOC->ISSUE->IDLE
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ALLOC = 3'd3,
        ST_ISSUE = 3'd4
    } state_t;

endpackage

// File: rtl/dlsc_pcie_s6_outbound_read_credit.sv
// Outstanding-tag and free-dword bookkeeping for the read completion buffer.
// Tracks allocations against dealloc feedback and reports whether a request fits.
module dlsc_pcie_s6_outbound_read_credit #(
    parameter int LEN  = 4,
    parameter int TAG  = 5,
    parameter int BUFA = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [TAG:0]   cfgTags_i,
    input  logic           alloc_i,
    input  logic [LEN-1:0] allocLen_i,
    input  logic [LEN-1:0] reqLen_i,
    input  logic           deallocTag_i,
    input  logic           deallocData_i,
    output logic           hasSpace_o
);

    localparam int DW = BUFA + 1;
    localparam logic [BUFA:0] DW_FULL = DW'(1) << BUFA;

    logic [TAG:0]  tagsOut_q;
    logic [TAG:0]  tagsOut_d;
    logic [BUFA:0] dwFree_q;
    logic [BUFA:0] dwFree_d;
    logic [BUFA:0] allocDw;
    logic [BUFA:0] reqDw;

    assign allocDw = alloc_i ? (DW'(allocLen_i) + DW'(1)) : '0;
    assign reqDw   = DW'(reqLen_i) + DW'(1);

    // Net the allocation and dealloc pulses of the same cycle into next counts
    always_comb begin
        tagsOut_d = tagsOut_q;
        if (alloc_i && !deallocTag_i) begin
            tagsOut_d = tagsOut_q + (TAG+1)'(1);
        end else if (!alloc_i && deallocTag_i) begin
            tagsOut_d = tagsOut_q - (TAG+1)'(1);
        end
        dwFree_d = dwFree_q + DW'(deallocData_i) - allocDw;
    end

    // Counter registers; the buffer starts completely free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tagsOut_q <= '0;
            dwFree_q  <= DW_FULL;
        end else begin
            tagsOut_q <= tagsOut_d;
            dwFree_q  <= dwFree_d;
        end
    end

    // Freeing a tag or dword that was never handed out means the buffer lost sync
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(deallocTag_i && tagsOut_q == '0));
            assert (!(deallocData_i && dwFree_q == DW_FULL));
        end
    end

    assign hasSpace_o = (tagsOut_q < cfgTags_i) && (dwFree_q >= reqDw);

endmodule

// File: rtl/dlsc_pcie_s6_outbound_read_alloc.sv
// Outbound read allocator: accepts one AXI read command at a time, reserves a
// PCIe tag plus a contiguous dword region, writes the tag table entry, then
// offers the read-request descriptor to the TLP generator.
module dlsc_pcie_s6_outbound_read_alloc
    import dlsc_pcie_s6_outbound_read_pkg::*;
#(
    parameter int ADDR = 32,
    parameter int LEN  = 4,
    parameter int TAG  = 5,
    parameter int BUFA = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TAG:0]    cfg_tags,
    output logic            axi_ar_ready,
    input  logic            axi_ar_valid,
    input  logic [ADDR-1:0] axi_ar_addr,
    input  logic [LEN-1:0]  axi_ar_len,
    input  logic            tlp_ready,
    output logic            tlp_valid,
    output logic [ADDR-3:0] tlp_addr,
    output logic [LEN:0]    tlp_len,
    output logic [TAG-1:0]  tlp_tag,
    output logic            alloc_init,
    output logic            alloc_valid,
    output logic [TAG:0]    alloc_tag,
    output logic [BUFA-1:0] alloc_bufa,
    input  logic            dealloc_tag,
    input  logic            dealloc_data
);

    localparam int LW = LEN + 1;
    localparam int BW = BUFA;

    state_t          state_q;
    logic            arReady_q;
    logic            allocInit_q;
    logic            allocValid_q;
    logic [TAG:0]    allocTag_q;
    logic [BUFA-1:0] allocBufa_q;
    logic            tlpValid_q;
    logic [ADDR-3:0] tlpAddr_q;
    logic [LEN:0]    tlpLen_q;
    logic [TAG-1:0]  tlpTag_q;
    logic [LEN-1:0]  len_q;
    logic            hasSpace;
    logic [1:0]      unusedAddrLsb;

    // Byte offset within a dword carries no meaning for dword reads
    assign unusedAddrLsb = axi_ar_addr[1:0];

    dlsc_pcie_s6_outbound_read_credit #(
        .LEN  (LEN),
        .TAG  (TAG),
        .BUFA (BUFA)
    ) uCredit (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfgTags_i     (cfg_tags),
        .alloc_i       (allocValid_q),
        .allocLen_i    (len_q),
        .reqLen_i      (len_q),
        .deallocTag_i  (dealloc_tag),
        .deallocData_i (dealloc_data),
        .hasSpace_o    (hasSpace)
    );

    // Command sequencer with registered handshakes, pointers and descriptor
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            arReady_q    <= 1'b0;
            allocInit_q  <= 1'b1;
            allocValid_q <= 1'b0;
            allocTag_q   <= '0;
            allocBufa_q  <= '0;
            tlpValid_q   <= 1'b0;
            tlpAddr_q    <= '0;
            tlpLen_q     <= '0;
            tlpTag_q     <= '0;
            len_q        <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    allocInit_q <= 1'b0;
                    arReady_q   <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (axi_ar_valid && arReady_q) begin
                        arReady_q <= 1'b0;
                        tlpAddr_q <= axi_ar_addr[ADDR-1:2];
                        tlpLen_q  <= LW'(axi_ar_len) + LW'(1);
                        len_q     <= axi_ar_len;
                        state_q   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hasSpace) begin
                        allocValid_q <= 1'b1;
                        tlpValid_q   <= 1'b1;
                        tlpTag_q     <= allocTag_q[TAG-1:0];
                        state_q      <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    allocValid_q <= 1'b0;
                    allocTag_q   <= allocTag_q + (TAG+1)'(1);
                    allocBufa_q  <= allocBufa_q + BW'(len_q) + BW'(1);
                    if (tlp_ready) begin
                        tlpValid_q <= 1'b0;
                    end
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!tlpValid_q || tlp_ready) begin
                        tlpValid_q <= 1'b0;
                        arReady_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign axi_ar_ready = arReady_q;
    assign alloc_init   = allocInit_q;
    assign alloc_valid  = allocValid_q;
    assign alloc_tag    = allocTag_q;
    assign alloc_bufa   = allocBufa_q;
    assign tlp_valid    = tlpValid_q;
    assign tlp_addr     = tlpAddr_q;
    assign tlp_len      = tlpLen_q;
    assign tlp_tag      = tlpTag_q;

endmodule
